// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Requester-side and memory-side bus bundle for mem_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic [AW-1:0] m0_addr;
    logic          m0_ren;
    logic          m0_wen;
    logic [31:0]   m0_wdata;
    logic [1:0]    m0_wsize;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [31:0]   m0_rdata;

    logic [AW-1:0] m1_addr;
    logic          m1_ren;
    logic          m1_wen;
    logic [31:0]   m1_wdata;
    logic [1:0]    m1_wsize;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [31:0]   m1_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_ren;
    logic          mem_wen;
    logic [31:0]   mem_wdata;
    logic [1:0]    mem_wsize;
    logic [31:0]   mem_rdata;

    modport slave (
        input  m0_addr, m0_ren, m0_wen, m0_wdata, m0_wsize,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_addr, m1_ren, m1_wen, m1_wdata, m1_wsize,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_ren, mem_wen, mem_wdata, mem_wsize,
        input  mem_rdata
    );

    modport master (
        output m0_addr, m0_ren, m0_wen, m0_wdata, m0_wsize,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_addr, m1_ren, m1_wen, m1_wdata, m1_wsize,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_ren, mem_wen, mem_wdata, mem_wsize,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter for one single-port memory; fixed priority
//            by default, round-robin when MEM_ARBITER_ROUND_ROBIN_EN is defined.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int AW = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT0 = 3'd1,
        S_GRANT1 = 3'd2,
        S_RESP0  = 3'd3,
        S_RESP1  = 3'd4
    } state_e;

    state_e        state_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_ren_q;
    logic          mem_wen_q;
    logic [31:0]   mem_wdata_q;
    logic [1:0]    mem_wsize_q;

    logic          w_req0;
    logic          w_req1;
    logic          w_pick1;

    assign w_req0 = bus.m0_ren | bus.m0_wen;
    assign w_req1 = bus.m1_ren | bus.m1_wen;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // last_grant_q holds the index of the most recently granted port.
    logic last_grant_q;
    assign w_pick1 = w_req1 & (~w_req0 | ~last_grant_q);
`else
    assign w_pick1 = w_req1 & ~w_req0;
`endif

    // The winner's request is captured in IDLE; requesters hold it stable
    // until gnt, so the captured copy equals the live port during GRANT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_wsize_q <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_req0 | w_req1) begin
                        state_q     <= w_pick1 ? S_GRANT1 : S_GRANT0;
                        gnt0_q      <= ~w_pick1;
                        gnt1_q      <= w_pick1;
                        mem_addr_q  <= w_pick1 ? bus.m1_addr  : bus.m0_addr;
                        mem_ren_q   <= w_pick1 ? bus.m1_ren   : bus.m0_ren;
                        mem_wen_q   <= w_pick1 ? bus.m1_wen   : bus.m0_wen;
                        mem_wdata_q <= w_pick1 ? bus.m1_wdata : bus.m0_wdata;
                        mem_wsize_q <= w_pick1 ? bus.m1_wsize : bus.m0_wsize;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_grant_q <= w_pick1;
`endif
                    end
                end
                S_GRANT0, S_GRANT1: begin
                    gnt0_q      <= 1'b0;
                    gnt1_q      <= 1'b0;
                    rvalid0_q   <= (state_q == S_GRANT0) & mem_ren_q;
                    rvalid1_q   <= (state_q == S_GRANT1) & mem_ren_q;
                    if (mem_ren_q) begin
                        state_q <= (state_q == S_GRANT0) ? S_RESP0 : S_RESP1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                    mem_addr_q  <= '0;
                    mem_ren_q   <= 1'b0;
                    mem_wen_q   <= 1'b0;
                    mem_wdata_q <= '0;
                    mem_wsize_q <= '0;
                end
                S_RESP0, S_RESP1: begin
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Reset masks strobes in the same cycle it is asserted, before the edge.
    assign bus.m0_gnt    = gnt0_q & ~reset;
    assign bus.m1_gnt    = gnt1_q & ~reset;
    assign bus.m0_rvalid = rvalid0_q & ~reset;
    assign bus.m1_rvalid = rvalid1_q & ~reset;
    assign bus.m0_rdata  = bus.mem_rdata;
    assign bus.m1_rdata  = bus.mem_rdata;

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_ren   = mem_ren_q & ~reset;
    assign bus.mem_wen   = mem_wen_q & ~reset;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wsize = mem_wsize_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of both requester ports and the memory port.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: m0_addr  in  AW  requester 0 (CPU) byte address.
REQ-006 Port: m0_ren / m0_wen  in  1 each  requester 0 read/write request.
REQ-007 Port: m0_wdata  in  32, m0_wsize  in  2  write data; size code 01=byte, 10=half, 11=word.
REQ-008 Port: m0_gnt  out  1  access accepted this cycle.
REQ-009 Port: m0_rvalid  out  1  m0_rdata valid this cycle.
REQ-010 Port: m0_rdata  out  32  read data.
REQ-011 Port: m1_* are identical to REQ-005..REQ-010 for requester 1 (loader/DMA).
REQ-012 Port: mem_addr  out  AW; mem_ren, mem_wen  out  1; mem_wdata  out  32; mem_wsize  out  2  to the single-port memory.
REQ-013 Port: mem_rdata  in  32  memory read data, registered; valid the cycle after mem_ren.

Function
REQ-014 A request mK_req is defined as mK_ren | mK_wen; a requester SHALL hold addr/ren/wen/wdata/wsize stable from assertion until the cycle mK_gnt=1.
REQ-015 The FSM SHALL have states IDLE, GRANT0, GRANT1, RESP0, RESP1.
REQ-016 In IDLE the FSM SHALL select a winner among active requests and move to GRANTk; with no request it SHALL stay in IDLE.
REQ-017 In GRANTk, mem_* SHALL be driven from port k, mK_gnt=1 for exactly that cycle, and all other mem_ren/mem_wen SHALL be 0.
REQ-018 From GRANTk the FSM SHALL go to RESPk if mK_ren was 1, else to IDLE.
REQ-019 In RESPk, mK_rvalid=1 for exactly one cycle; the FSM then returns to IDLE.
REQ-020 Read latency: request in cycle N (IDLE) -> gnt in N+1 -> rvalid in N+2; write latency: gnt in N+1, memory updated on the N+1 edge.
REQ-021 Simultaneous ren and wen on one port SHALL be forwarded together; rvalid follows as for a read.
REQ-022 m0_rdata and m1_rdata SHALL both equal mem_rdata at all times; only mK_rvalid qualifies them.
REQ-023 Outside GRANTk, mem_ren=mem_wen=0 and mem_addr/mem_wdata/mem_wsize SHALL be 0.
REQ-024 A request dropped before gnt SHALL be ignored by the arbiter (no error, no grant).
REQ-025 Max throughput: one write per 2 cycles, one read per 3 cycles.

Reset
REQ-026 On reset: state=IDLE, all gnt/rvalid=0, mem_ren=mem_wen=0, last_grant=1.
REQ-027 Reset asserted in GRANTk SHALL force mem_wen=0 and mem_ren=0 in that cycle; no rvalid SHALL follow.
REQ-028 Reset asserted in RESPk SHALL suppress mK_rvalid in that cycle.

Configuration
REQ-029 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: on contention the port not equal to last_grant SHALL win; last_grant SHALL update on every grant.
REQ-030 Macro undefined: fixed priority, port 0 SHALL always win contention; last_grant SHALL be unused.

Verification
REQ-031 m0 read addr 0x80000004 (mem word 0x00112233), m1 idle -> m0_gnt cycle 1, m0_rvalid cycle 2 with m0_rdata=0x00112233, return to IDLE cycle 3.
REQ-032 m1 write 0x000000A5 wsize=01 addr 0x10 -> m1_gnt 1 cycle, mem_wen=1 same cycle, no rvalid; later m0 read of 0x10 returns low byte 0xA5.
REQ-033 m0 and m1 both read continuously from reset, round-robin build -> grants alternate m0,m1,m0,m1; fixed build -> m0 granted every 3 cycles, m1 never.
REQ-034 Reset pulsed in GRANT0 of a write of 0xDEADBEEF -> mem_wen=0 that cycle, memory unchanged, state IDLE, no m0_gnt.
REQ-035 Reset pulsed in RESP1 -> m1_rvalid stays 0, next cycle IDLE, subsequent m1 read completes normally with 3-cycle latency.
REQ-036 m1 raises ren for 1 cycle while m0 holds GRANT0 then drops -> m1 never granted, mem_ren never driven from m1.
